// File: rtl/keypad_debounce_decode.sv
// Single-key debouncer and hex decoder for a column-scanned 4x4 keypad.
// Accepts a press and a release after DEBOUNCE_SCANS consecutive samples of the key's column.
module keypad_debounce_decode #(
  parameter int DEBOUNCE_SCANS = 4  // legal range 2..255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rcbits,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down,
  output logic       key_release
);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED} state_t;

  localparam logic [7:0] SCANS = 8'(DEBOUNCE_SCANS);

  state_t     state_q, state_d;
  logic [3:0] cand_row_q, cand_row_d;
  logic [3:0] cand_col_q, cand_col_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] rel_q, rel_d;
  logic [3:0] key_code_q, key_code_d;
  logic       key_valid_q, key_valid_d;
  logic       key_down_q, key_down_d;
  logic       key_release_q, key_release_d;

  logic [3:0] row, col;
  logic       col_ok, hit, cand_sample;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    case (v)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] decode(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: return 4'h1;  4'h1: return 4'h2;  4'h2: return 4'h3;  4'h3: return 4'hA;
      4'h4: return 4'h4;  4'h5: return 4'h5;  4'h6: return 4'h6;  4'h7: return 4'hB;
      4'h8: return 4'h7;  4'h9: return 4'h8;  4'hA: return 4'h9;  4'hB: return 4'hC;
      4'hC: return 4'hE;  4'hD: return 4'h0;  4'hE: return 4'hF;  default: return 4'hD;
    endcase
  endfunction

  // Counters clamp at SCANS so a long hold can never wrap them.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v >= SCANS) ? SCANS : v + 8'd1;
  endfunction

  assign row         = rcbits[7:4];
  assign col         = rcbits[3:0];
  assign col_ok      = is_onehot(col);
  assign hit         = col_ok && is_onehot(row);
  assign cand_sample = col_ok && (col == cand_col_q);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    cand_row_d    = cand_row_q;
    cand_col_d    = cand_col_q;
    cnt_d         = cnt_q;
    rel_d         = rel_q;
    key_code_d    = key_code_q;
    key_valid_d   = 1'b0;
    key_down_d    = key_down_q;
    key_release_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (hit) begin
          cand_row_d = row;
          cand_col_d = col;
          cnt_d      = 8'd1;
          state_d    = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (cand_sample) begin
          if (row == cand_row_q) begin
            cnt_d = sat_inc(cnt_q);
            if (cnt_d == SCANS) begin
              key_code_d  = decode(onehot_idx(cand_row_q), onehot_idx(cand_col_q));
              key_valid_d = 1'b1;
              key_down_d  = 1'b1;
              rel_d       = 8'd0;
              state_d     = PRESSED;
            end
          end else begin
            cnt_d   = 8'd0;
            state_d = IDLE;
          end
        end
      end
      PRESSED: begin
        // Extra rows on the same column are tolerated as long as our row stays set.
        if (cand_sample) begin
          if ((row & cand_row_q) == 4'd0) begin
            rel_d = sat_inc(rel_q);
            if (rel_d == SCANS) begin
              key_down_d    = 1'b0;
              key_release_d = 1'b1;
              cnt_d         = 8'd0;
              state_d       = IDLE;
            end
          end else begin
            rel_d = 8'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cand_row_q    <= 4'd0;
      cand_col_q    <= 4'd0;
      cnt_q         <= 8'd0;
      rel_q         <= 8'd0;
      key_code_q    <= 4'd0;
      key_valid_q   <= 1'b0;
      key_down_q    <= 1'b0;
      key_release_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cand_row_q    <= cand_row_d;
      cand_col_q    <= cand_col_d;
      cnt_q         <= cnt_d;
      rel_q         <= rel_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_down_q    <= key_down_d;
      key_release_q <= key_release_d;
    end
  end

  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_down    = key_down_q;
  assign key_release = key_release_q;

endmodule

// File: tb/tb_keypad_debounce_decode.sv
// Directed bench for keypad_debounce_decode: a vector table applied one sample per clock,
// followed by hand-written reset sequences.
module tb_keypad_debounce_decode;

  typedef struct {
    logic [7:0] rc;
    logic       v;
    logic       d;
    logic       r;
    logic [3:0] code;
    string      tag;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rcbits;
  logic [3:0] key_code;
  logic       key_valid, key_down, key_release;

  int checks   = 0;
  int failures = 0;
  vec_t vecs[$];

  keypad_debounce_decode #(.DEBOUNCE_SCANS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .rcbits     (rcbits),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_down   (key_down),
    .key_release(key_release)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [7:0] rc, input logic v, input logic d, input logic r,
                     input logic [3:0] code, input string tag);
    vec_t e;
    e.rc = rc; e.v = v; e.d = d; e.r = r; e.code = code; e.tag = tag;
    vecs.push_back(e);
  endtask

  // Drive one sample at a falling edge, let the rising edge register it, check at the next fall.
  task automatic step(input logic [7:0] rc, input logic v, input logic d, input logic r,
                      input logic [3:0] code, input string tag);
    rcbits = rc;
    @(negedge clk);
    check({tag, ".valid"},   {7'd0, key_valid},   {7'd0, v});
    check({tag, ".down"},    {7'd0, key_down},    {7'd0, d});
    check({tag, ".release"}, {7'd0, key_release}, {7'd0, r});
    check({tag, ".code"},    {4'd0, key_code},    {4'd0, code});
    check({tag, ".excl"},    {7'd0, key_valid & key_release}, 8'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".valid"},   {7'd0, key_valid},   8'd0);
    check({tag, ".down"},    {7'd0, key_down},    8'd0);
    check({tag, ".release"}, {7'd0, key_release}, 8'd0);
    check({tag, ".code"},    {4'd0, key_code},    8'd0);
  endtask

  initial begin
    logic [3:0] one;
    logic [3:0] col;
    one = 4'b0001;

    // Scanner cycles columns each clock; key row1/col2 held, col2 seen at samples 0,4,8,12.
    for (int c = 0; c < 16; c++) begin
      col = one << ((c + 2) % 4);
      add((col == 4'b0100) ? 8'h24 : {4'h0, col}, c == 12, c >= 12, 1'b0,
          (c >= 12) ? 4'h6 : 4'h0, "press_6");
    end
    // Key released: col2 samples at 16,20,24,28 show an empty row field.
    for (int c = 16; c < 32; c++) begin
      col = one << ((c + 2) % 4);
      add((col == 4'b0100) ? 8'h04 : {4'h0, col}, 1'b0, c < 28, c == 28, 4'h6, "release_6");
    end
    // Bounce on row0/col0: two hits, a miss, then four clean hits.
    add(8'h11, 0, 0, 0, 4'h6, "bounce");
    add(8'h11, 0, 0, 0, 4'h6, "bounce");
    add(8'h01, 0, 0, 0, 4'h6, "bounce_miss");
    add(8'h11, 0, 0, 0, 4'h6, "bounce_retry");
    add(8'h11, 0, 0, 0, 4'h6, "bounce_retry");
    add(8'h11, 0, 0, 0, 4'h6, "bounce_retry");
    add(8'h11, 1, 1, 0, 4'h1, "bounce_accept");
    add(8'h01, 0, 1, 0, 4'h1, "release_1");
    add(8'h01, 0, 1, 0, 4'h1, "release_1");
    add(8'h01, 0, 1, 0, 4'h1, "release_1");
    add(8'h01, 0, 0, 1, 4'h1, "release_1_pulse");
    // Multi-row on col3 is a miss; then row3/col3 with a bad column word injected between hits.
    add(8'h58, 0, 0, 0, 4'h1, "multirow");
    add(8'h58, 0, 0, 0, 4'h1, "multirow");
    add(8'h58, 0, 0, 0, 4'h1, "multirow");
    add(8'h88, 0, 0, 0, 4'h1, "press_D");
    add(8'h88, 0, 0, 0, 4'h1, "press_D");
    add(8'hF3, 0, 0, 0, 4'h1, "bad_col");
    add(8'h88, 0, 0, 0, 4'h1, "press_D");
    add(8'h88, 1, 1, 0, 4'hD, "accept_D");
    // Second key (row0/col0) and an extra row on col3 while D is held: no events.
    add(8'h11, 0, 1, 0, 4'hD, "lockout");
    add(8'h98, 0, 1, 0, 4'hD, "lockout");
    add(8'h11, 0, 1, 0, 4'hD, "lockout");
    add(8'h98, 0, 1, 0, 4'hD, "lockout");
    add(8'h11, 0, 1, 0, 4'hD, "lockout");
    add(8'h88, 0, 1, 0, 4'hD, "lockout");
    // D released while the second key stays held on col0.
    add(8'h08, 0, 1, 0, 4'hD, "lockout_rel");
    add(8'h11, 0, 1, 0, 4'hD, "lockout_rel");
    add(8'h08, 0, 1, 0, 4'hD, "lockout_rel");
    add(8'h11, 0, 1, 0, 4'hD, "lockout_rel");
    add(8'h08, 0, 1, 0, 4'hD, "lockout_rel");
    add(8'h11, 0, 1, 0, 4'hD, "lockout_rel");
    add(8'h08, 0, 0, 1, 4'hD, "lockout_rel_pulse");
    add(8'h00, 0, 0, 0, 4'hD, "idle_after");
    add(8'h00, 0, 0, 0, 4'hD, "idle_after");

    reset  = 1'b1;
    rcbits = 8'h00;
    repeat (2) @(negedge clk);
    check_all_zero("reset_state");
    reset = 1'b0;

    foreach (vecs[i])
      step(vecs[i].rc, vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].code, vecs[i].tag);

    // Press row2/col1 (code 8), then assert reset mid-press.
    step(8'h42, 0, 0, 0, 4'hD, "press_8");
    step(8'h42, 0, 0, 0, 4'hD, "press_8");
    step(8'h42, 0, 0, 0, 4'hD, "press_8");
    step(8'h42, 1, 1, 0, 4'h8, "accept_8");
    step(8'h42, 0, 1, 0, 4'h8, "held_8");
    #2 reset = 1'b1;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    check_all_zero("reset_held");
    reset = 1'b0;
    // Key still held after reset: re-debounced from scratch.
    step(8'h42, 0, 0, 0, 4'h0, "redebounce_8");
    step(8'h42, 0, 0, 0, 4'h0, "redebounce_8");
    step(8'h42, 0, 0, 0, 4'h0, "redebounce_8");
    step(8'h42, 1, 1, 0, 4'h8, "reaccept_8");
    step(8'h42, 0, 1, 0, 4'h8, "reheld_8");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
